// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   // Operation sequencer states: wait for operands, walk the digits, hold result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Nines complement of a digit, modulo 16 so that invalid digits still give
   // a deterministic value.
   function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
      return bcd_digit_t'(4'd9 - d);
   endfunction

   // True for the legal BCD codes 0..9.
   function automatic logic digit_valid(input bcd_digit_t d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit of add/subtract: optional nines complement of b, binary add
// with carry, then the +6 decimal correction when the raw sum exceeds 9.
import bcd_pkg::*;

module bcd_digit_adder (
   input  bcd_digit_t a_d,
   input  bcd_digit_t b_d,
   input  logic       cin,
   input  logic       sub,
   output bcd_digit_t digit,
   output logic       cout
);

   bcd_digit_t b_eff;
   logic [4:0] raw;

   // Digit add with decimal correction; a raw sum above 9 wraps by +6 and carries.
   always_comb begin
      b_eff = sub ? nines_comp(b_d) : b_d;
      raw   = {1'b0, a_d} + {1'b0, b_eff} + {4'b0000, cin};
      digit = raw[3:0];
      cout  = 1'b0;
      if (raw > 5'd9) begin
         digit = bcd_digit_t'(raw[3:0] + 4'd6);
         cout  = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor. Operands are taken once, then one digit
// is produced per clock (least significant first) through a single shared
// digit adder; the packed result is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE.
// Neither side may assume a transfer without both signals high, and valid
// asserted against a low ready is simply ignored.
import bcd_pkg::*;

module bcd_serial_addsub #(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] a,
   input  logic [4*NDIGITS-1:0] b,
   input  logic                 sub,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NDIGITS-1:0] sum,
   output logic                 cout,
   output logic                 err,
   output state_t               dbg_state
);

   localparam int W  = BCD_DIGIT_W * NDIGITS;
   localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          sub_r;
   logic          carry;
   logic          bad_in;
   logic          accept;
   logic          last_digit;
   bcd_digit_t    a_sel;
   bcd_digit_t    b_sel;
   bcd_digit_t    dig;
   logic          dig_cout;

   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt == LAST);
   assign dbg_state  = state;

   // Flag any non-BCD code among the incoming operand digits.
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (!digit_valid(a[BCD_DIGIT_W*i +: BCD_DIGIT_W]) ||
             !digit_valid(b[BCD_DIGIT_W*i +: BCD_DIGIT_W]))
            bad_in = 1'b1;
      end
   end

   // Route the digit pair selected by the counter to the shared adder.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (cnt == CW'(i)) begin
            a_sel = a_r[BCD_DIGIT_W*i +: BCD_DIGIT_W];
            b_sel = b_r[BCD_DIGIT_W*i +: BCD_DIGIT_W];
         end
      end
   end

   bcd_digit_adder u_digit (
      .a_d   (a_sel),
      .b_d   (b_sel),
      .cin   (carry),
      .sub   (sub_r),
      .digit (dig),
      .cout  (dig_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and handshake outputs decoded from the current state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = RUN;
         end
         RUN: begin
            if (last_digit)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept, then one result digit per RUN cycle.
   // In subtract mode the initial carry is inverted so that cin acts as a
   // borrow-in on top of the ten's-complement +1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         sub_r <= 1'b0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= cin ^ sub;
            err   <= bad_in;
            cnt   <= '0;
         end else if (state == RUN) begin
            for (int i = 0; i < NDIGITS; i++) begin
               if (cnt == CW'(i))
                  sum[BCD_DIGIT_W*i +: BCD_DIGIT_W] <= dig;
            end
            carry <= dig_cout;
            if (last_digit) begin
               cout <= dig_cout;
               cnt  <= '0;
            end else begin
               cnt  <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: directed cases plus random
// operations compared against an integer-arithmetic decimal model.
import bcd_pkg::*;

module tb_bcd_serial_addsub;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;

   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;
   state_t       dbg_state;

   logic         in_valid1 = 1'b0;
   logic         in_ready1;
   logic [3:0]   a1 = '0;
   logic [3:0]   b1 = '0;
   logic         sub1 = 1'b0;
   logic         cin1 = 1'b0;
   logic         out_valid1;
   logic         out_ready1 = 1'b1;
   logic [3:0]   sum1;
   logic         cout1;
   logic         err1;
   state_t       dbg_state1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [W:0] exp_q[$];

   bcd_serial_addsub #(.NDIGITS(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .err(err),
      .dbg_state(dbg_state)
   );

   bcd_serial_addsub #(.NDIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .cin(cin1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .cout(cout1), .err(err1),
      .dbg_state(dbg_state1)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int bcd2int(input logic [W-1:0] x, input int n);
      int v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v, input int n);
      logic [W-1:0] r = '0;
      int t = v;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Decimal add/sub of n-digit numbers; cout is carry-out (add) or
   // not-borrow (sub), and a negative difference wraps modulo 10^n.
   task automatic model(input int av, input int bv, input logic s, input logic c,
                        input int n, output logic [W-1:0] res, output logic co);
      int pw = 1;
      int t;
      for (int i = 0; i < n; i++) pw = pw * 10;
      if (!s) begin
         t  = av + bv + int'(c);
         co = (t >= pw);
         t  = t % pw;
      end else begin
         t  = av - bv - int'(c);
         co = (t >= 0);
         if (t < 0) t = t + pw;
      end
      res = int2bcd(t, n);
   endtask

   // ---------------- drivers ----------------
   // Called #1 after a rising edge; returns with the result consumed,
   // again #1 after a rising edge.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic c,
                         output logic [W-1:0] rs, output logic rc, output logic re,
                         output int lat, output int acc, output logic ok);
      a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      ok = (out_valid === 1'b1);
      rs = sum; rc = cout; re = err;
      @(posedge clk); #1;
   endtask

   task automatic run_op1(input logic [3:0] av, input logic [3:0] bv,
                          input logic s, input logic c,
                          output logic [3:0] rs, output logic rc, output int lat);
      a1 = av; b1 = bv; sub1 = s; cin1 = c; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = sum1; rc = cout1;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      total++;
      if (sum !== '0 || cout !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL reset_out: sum=%h cout=%b err=%b want 0 0 0", sum, cout, err);
      end
      total++;
      if (dbg_state !== IDLE) begin
         bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state);
      end
   endtask

   task automatic test_add();
      logic [W-1:0] ta[3] = '{16'h0045, 16'h9999, 16'h0099};
      logic [W-1:0] tb[3] = '{16'h0027, 16'h0001, 16'h0001};
      logic         tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] rs, es;
      logic rc, re, ec, ok;
      int lat, acc;
      for (int i = 0; i < 3; i++) begin
         model(bcd2int(ta[i], N), bcd2int(tb[i], N), 1'b0, tc[i], N, es, ec);
         run_op(ta[i], tb[i], 1'b0, tc[i], rs, rc, re, lat, acc, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL add_timeout[%0d]: no out_valid within bound", i); end
         total++;
         if (rs !== es || rc !== ec || re !== 1'b0) begin
            bad++; $display("FAIL add[%0d]: sum=%h cout=%b err=%b want %h %b 0", i, rs, rc, re, es, ec);
         end
         // out_valid first seen N edges after the accepting edge, i.e. in the
         // (N+1)th cycle counting the accept cycle.
         total++;
         if (lat != N) begin bad++; $display("FAIL add_latency[%0d]: got %0d want %0d", i, lat, N); end
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] ta[3] = '{16'h0100, 16'h0044, 16'h0056};
      logic [W-1:0] tb[3] = '{16'h0044, 16'h0100, 16'h0056};
      logic         tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] rs, es;
      logic rc, re, ec, ok;
      int lat, acc;
      for (int i = 0; i < 3; i++) begin
         model(bcd2int(ta[i], N), bcd2int(tb[i], N), 1'b1, tc[i], N, es, ec);
         run_op(ta[i], tb[i], 1'b1, tc[i], rs, rc, re, lat, acc, ok);
         total++;
         if (!ok || rs !== es || rc !== ec || re !== 1'b0) begin
            bad++; $display("FAIL sub[%0d]: sum=%h cout=%b err=%b want %h %b 0", i, rs, rc, re, es, ec);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] es;
      logic ec;
      int lat;
      model(123, 456, 1'b0, 1'b0, N, es, ec);
      out_ready = 1'b0;
      a = 16'h0123; b = 16'h0456; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
      // New operands offered while the result is held must be ignored.
      a = 16'h9999; b = 16'h9999; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if (sum !== es || cout !== ec || err !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: sum=%h cout=%b err=%b ov=%b ir=%b want %h %b 0 1 0",
                     i, sum, cout, err, out_valid, in_ready, es, ec);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (dbg_state !== IDLE || sum !== es) begin
         bad++; $display("FAIL bp_no_accept: state=%0d sum=%h want IDLE %h", dbg_state, sum, es);
      end
   endtask

   task automatic test_invalid();
      logic [W-1:0] rs;
      logic rc, re, ok;
      int lat, acc;
      run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, rs, rc, re, lat, acc, ok);
      total++;
      if (re !== 1'b1) begin bad++; $display("FAIL inv_err: got %b want 1", re); end
      total++;
      if (!ok || lat != N) begin bad++; $display("FAIL inv_latency: got %0d want %0d", lat, N); end
      // Digit rule applied to A=10: 10+0 -> 0 carry 1, giving 0101.
      total++;
      if (rs !== 16'h0101 || rc !== 1'b0) begin
         bad++; $display("FAIL inv_sum: sum=%h cout=%b want 0101 0", rs, rc);
      end
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, re, lat, acc, ok);
      total++;
      if (re !== 1'b0 || rs !== 16'h0002) begin
         bad++; $display("FAIL inv_recover: sum=%h err=%b want 0002 0", rs, re);
      end
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] rs, es;
      logic rc, re, ec, ok;
      int lat, acc;
      a = 16'h0045; b = 16'h0027; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1 || cout !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL midrun_reset: ov=%b sum=%h ir=%b cout=%b err=%b want 0 0 1 0 0",
                  out_valid, sum, in_ready, cout, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      model(45, 27, 1'b0, 1'b0, N, es, ec);
      run_op(16'h0045, 16'h0027, 1'b0, 1'b0, rs, rc, re, lat, acc, ok);
      total++;
      if (!ok || rs !== es || rc !== ec) begin
         bad++; $display("FAIL midrun_after: sum=%h cout=%b want %h %b", rs, rc, es, ec);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] av, bv, rs, es;
      logic s, c, rc, re, ec, ok;
      logic [W:0] exp;
      int lat, acc;
      for (int k = 0; k < 25; k++) begin
         for (int i = 0; i < N; i++) begin
            av[4*i +: 4] = 4'($urandom_range(0, 9));
            bv[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         s = 1'($urandom_range(0, 1));
         c = 1'($urandom_range(0, 1));
         model(bcd2int(av, N), bcd2int(bv, N), s, c, N, es, ec);
         exp_q.push_back({ec, es});
         run_op(av, bv, s, c, rs, rc, re, lat, acc, ok);
         exp = exp_q.pop_front();
         total++;
         if (!ok || {rc, rs} !== exp || re !== 1'b0) begin
            bad++;
            $display("FAIL rand[%0d]: %h %s %h cin=%b got cout=%b sum=%h err=%b want %b %h 0",
                     k, av, s ? "-" : "+", bv, c, rc, rs, re, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] rs, es;
      logic rc, re, ec, ok;
      int lat, acc, prev;
      prev = -1;
      for (int k = 0; k < 3; k++) begin
         model(1111 * (k + 1), 2222, 1'b0, 1'b1, N, es, ec);
         run_op(int2bcd(1111 * (k + 1), N), 16'h2222, 1'b0, 1'b1, rs, rc, re, lat, acc, ok);
         total++;
         if (!ok || rs !== es || rc !== ec) begin
            bad++; $display("FAIL b2b[%0d]: sum=%h cout=%b want %h %b", k, rs, rc, es, ec);
         end
         if (prev >= 0) begin
            total++;
            if (acc - prev != N + 2) begin
               bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, acc - prev, N + 2);
            end
         end
         prev = acc;
      end
   endtask

   task automatic test_ndigits1();
      logic [3:0] ta[2] = '{4'h5, 4'h5};
      logic [3:0] tb[2] = '{4'h4, 4'h7};
      logic [W-1:0] es;
      logic [3:0] rs;
      logic rc, ec;
      int lat;
      for (int i = 0; i < 2; i++) begin
         model(int'(ta[i]), int'(tb[i]), 1'b0, 1'b0, 1, es, ec);
         run_op1(ta[i], tb[i], 1'b0, 1'b0, rs, rc, lat);
         total++;
         if (rs !== es[3:0] || rc !== ec) begin
            bad++; $display("FAIL nd1[%0d]: sum=%h cout=%b want %h %b", i, rs, rc, es[3:0], ec);
         end
         total++;
         if (lat != 1) begin bad++; $display("FAIL nd1_latency[%0d]: got %0d want 1", i, lat); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_add();
      test_sub();
      test_backpressure();
      test_invalid();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      test_ndigits1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Parametrised, digit-serial BCD adder/subtractor, successor to the fixed 2-digit combinational BCD adder. Operands of NDIGITS packed BCD digits are accepted over a valid/ready handshake. One digit is processed per clock, least-significant digit first, and the result is held until the consumer takes it. It adds subtract mode, carry/borrow-in and invalid-digit detection, and sits between operand registers and a display or accumulator path.

Parameters:
NDIGITS, 4, number of BCD digits per operand (>=1); operand width = 4*NDIGITS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  operands/mode valid
in_ready  out  1  block can accept operands
a  in  4*NDIGITS  operand A, packed BCD, digit 0 in [3:0]
b  in  4*NDIGITS  operand B, packed BCD
sub  in  1  0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in)
cin  in  1  carry-in (add) / borrow-in (sub)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  4*NDIGITS  packed BCD result
cout  out  1  add: decimal carry-out; sub: 1 = no borrow (A>=B+cin), 0 = borrow
err  out  1  some digit of a or b was >9 in this operation

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0, digit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, sub and the initial carry (cin^sub). Set err if any digit of a or b is >9. Clear the counter. Go to RUN.
  - RUN: in_ready=0. Each cycle process digit i=counter:
    - b' = sub ? (9-b_i) mod 16 : b_i.
    - s = a_i + b' + carry, 5-bit.
    - If s>9: digit=(s+6) mod 16, carry=1. Else digit=s[3:0], carry=0.
    - Write digit into sum position i, increment counter.
    - After digit NDIGITS-1, go to DONE with cout=final carry.
  - DONE: out_valid=1. sum, cout and err are stable. On out_ready, go to IDLE, out_valid=0 next cycle.
- Latency: handshake on edge k. Digits are computed on edges k+1..k+NDIGITS. out_valid is high after edge k+NDIGITS, i.e. NDIGITS+1 cycles after accept.
- Throughput: one operation per NDIGITS+2 cycles minimum. There is no input/output overlap and in_ready=0 in RUN and DONE.
- Subtract result when cout=0 is the ten's complement of the magnitude, modulo 10^NDIGITS. No sign conversion is applied.
- Invalid digits: err=1 and the result is computed by the same rule. The result is not meaningful but is deterministic.
- sum holds its previous value in IDLE and is overwritten digit by digit in RUN.
- Counter width is $clog2(NDIGITS) with a minimum of 1. NDIGITS=1 is legal: RUN lasts one cycle.
- Reset mid-RUN or mid-DONE aborts the operation and all outputs return to reset values immediately.
- in_valid while not ready is ignored and no operands are latched. out_ready while out_valid=0 is ignored.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4
  - typedef bcd_digit_t (logic[3:0])
  - state enum {IDLE, RUN, DONE}
  - function nines_comp(bcd_digit_t)
  - function digit_valid(bcd_digit_t)
- Sub-module bcd_digit_adder: combinational, one digit. Inputs a_d, b_d, cin, sub. Outputs digit, cout. It performs the nines complement and the +6 correction. It is instantiated once and reused serially.

Test Plan:
1. NDIGITS=4, add 0045+0027, cin=0 -> sum=0072, cout=0, err=0, out_valid exactly 5 cycles after accept.
2. Add 9999+0001, cin=0 -> sum=0000, cout=1. Add 0099+0001 with cin=1 -> 0101, cout=0.
3. Subtract 0100-0044, cin=0 -> sum=0056, cout=1. Subtract 0044-0100 -> sum=9944, cout=0. Subtract 0056-0056 with cin=1 -> sum=9999, cout=0.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> sum, cout and err are stable and in_ready=0. Raise out_ready -> out_valid drops next cycle, in_ready=1. A new in_valid during DONE is not accepted.
5. Invalid digit: a=00A0, b=0001 -> err=1 and out_valid still asserts after 5 cycles. The next valid op, 0001+0001, gives err=0 and sum=0002.
6. Assert rst_n=0 on cycle 2 of RUN -> out_valid=0, sum=0, in_ready=1 asynchronously. After release, 0045+0027 -> 0072. Repeat test 1 with NDIGITS=1 (5+4 -> 9, 5+7 -> 2 cout=1).
